// File: rtl/ones_seq_ctrl.sv
// Bit-count sequencer: streams an operand bytewise through an external
// combinational Ones unit and accumulates the per-byte counts.
module ones_seq_ctrl #(
  parameter int NBYTES = 4,
  parameter int CW     = $clog2(8*NBYTES+1)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [8*NBYTES-1:0] in_word,
  output logic [7:0]          ones_y,
  input  logic [3:0]          ones_z,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [CW-1:0]       out_count,
  output logic                out_err
);

  localparam int W  = 8*NBYTES;
  localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int SW = CW + 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state;
  state_t state_nx;

  logic [W-1:0]  sh;
  logic [IW-1:0] idx;
  logic [CW-1:0] acc;
  logic          err;

  logic [SW-1:0] sum;
  logic [CW-1:0] acc_nx;
  logic          bad;
  logic          last;

  // One extra bit catches overflow so the total clamps instead of wrapping
  assign sum    = {1'b0, acc} + SW'(ones_z);
  assign acc_nx = sum[CW] ? '1 : sum[CW-1:0];
  assign bad    = ones_z > 4'd8;
  assign last   = idx == IW'(NBYTES-1);

  assign in_ready  = state == IDLE;
  assign out_valid = state == DONE;
  assign ones_y    = (state == RUN) ? sh[7:0] : 8'h00;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (in_valid)  state_nx = RUN;
      RUN:  if (last)      state_nx = DONE;
      DONE: if (out_ready) state_nx = IDLE;
      default:             state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sh        <= '0;
      idx       <= '0;
      acc       <= '0;
      err       <= 1'b0;
      out_count <= '0;
      out_err   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            sh  <= in_word;
            acc <= '0;
            idx <= '0;
            err <= 1'b0;
          end
        end
        RUN: begin
          acc <= acc_nx;
          sh  <= sh >> 8;
          idx <= idx + IW'(1);
          err <= err | bad;
          if (last) begin
            out_count <= acc_nx;
            out_err   <= err | bad;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: doc/ones_seq_ctrl.md
Name: ones_seq_ctrl

Overview:
- Multi-cycle sequencer that computes the population count of a wide operand using one shared 8-bit Ones counter unit (Y[7:0] in, Z[3:0] out).
- Accepts a word via a valid/ready handshake and feeds it to the Ones unit one byte per cycle, LSB byte first.
- Accumulates the per-byte counts and returns the total via a second valid/ready handshake.
- Sits beside the multi-cycle MIPS datapath as the bit-count execution resource; the Ones unit stays external and combinational.

Parameters:
- NBYTES, 4, number of bytes per operand; operand width is 8*NBYTES; legal range 1..16.
- CW, $clog2(8*NBYTES+1), width of the count result; 6 for the default.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-low; 0 = reset asserted.
- in_valid  input  1  operand offered.
- in_ready  output  1  controller can accept an operand.
- in_word  input  8*NBYTES  operand to count.
- ones_y  output  8  byte driven to the Ones unit Y input.
- ones_z  input  4  count returned combinationally by the Ones unit Z output.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts the result.
- out_count  output  CW  total number of ones in the operand.
- out_err  output  1  an out-of-range ones_z (>8) was seen during this operation.

Behaviour:
- Reset (reset=0, async): state=IDLE; shift reg, byte index, acc, out_count, out_err all 0; out_valid=0; ones_y=0.
- FSM states are IDLE, RUN and DONE.
- in_ready = (state==IDLE), combinational. out_valid = (state==DONE), registered.
- IDLE:
  - On a rising edge with in_valid=1: capture in_word into the shift reg; clear acc, idx and err_sticky; go to RUN.
  - in_valid=0: stay in IDLE.
- RUN (exactly NBYTES cycles):
  - ones_y = shift_reg[7:0], combinational from registers.
  - Each edge: acc <= acc + ones_z (zero-extended to CW); shift reg >>= 8; idx++.
  - If ones_z > 8: err_sticky <= 1, and ones_z is still added.
  - The accumulator saturates at 2^CW-1 and never wraps.
  - On the edge where idx==NBYTES-1: out_count <= acc + ones_z (saturated); out_err <= err_sticky | (ones_z>8); go to DONE.
- DONE:
  - out_count and out_err hold stable while out_valid=1.
  - ones_y=0.
  - On an edge with out_ready=1: go to IDLE. out_count and out_err keep their last value; only out_valid drops.
- ones_y = 0 in IDLE and DONE.
- Latency: operand accepted at edge k → out_valid=1 after edge k+NBYTES. Throughput is one operand per NBYTES+2 cycles with out_ready held at 1.
- in_valid while in RUN or DONE is ignored (in_ready=0). The source must hold the operand until in_ready=1.
- out_ready while not in DONE has no effect.
- Simultaneous out_ready in DONE and in_valid: no accept that cycle. The operand is accepted on the following edge from IDLE.
- Reset asserted mid-RUN or mid-DONE:
  - Immediate return to IDLE with all outputs at reset values.
  - The partial result is discarded and no out_valid pulse is produced.
- NBYTES=1: RUN lasts one cycle; idx comparison against 0.

Test Plan:
- in_word=0xFFFFFFFF, out_ready=1 → ones_y sequence FF,FF,FF,FF over 4 RUN cycles; out_valid after 4 edges; out_count=32; out_err=0.
- in_word=0x80402010 then 0x00000000 back-to-back → out_count=4, then out_count=0; ones_y byte order 10,20,40,80.
- in_word=0x0000F00F with out_ready held 0 for 5 cycles → out_valid stays 1; out_count=8 stable; in_ready=0; in_valid pulses ignored; returns to IDLE one edge after out_ready=1.
- Stub Ones model returns 9 on the second byte, true count elsewhere, in_word=0x01010101 → out_count=12; out_err=1. The next clean operand gives out_err=0.
- Accept 0xFFFFFFFF, assert reset=0 asynchronously mid-cycle after the 2nd RUN edge → out_valid=0, out_count=0 and ones_y=0 immediately; after release in_ready=1. A fresh 0x00000003 yields 2.
- NBYTES=1 build, in_word=0xA5 → one RUN cycle with ones_y=A5; out_count=4 after 1 edge.
